// File: rtl/laplace_pkg.sv
// Shared types and helpers for the Laplace streaming controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package laplace_pkg;

    localparam int PIX_W = 8;
    // Signed accumulator width: b+d+f+h-4e spans -1020..+1020.
    localparam int ACC_W = 11;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH,
        DONE
    } state_t;

    // Saturate a signed kernel sum into the 8-bit pixel range.
    function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [ACC_W-1:0] v);
        logic [PIX_W-1:0] r;
        if (v[ACC_W-1]) begin
            r = '0;
        end else if (|v[ACC_W-2:PIX_W]) begin
            r = '1;
        end else begin
            r = v[PIX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/laplace_line_buffer.sv
// Fixed-depth pixel delay line: dout_o is the value pushed DEPTH enables ago.
// Latency: DEPTH enabled cycles.
// Backpressure: none; the shift only advances when en_i is high.
module laplace_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Shift one position per enable; contents need no reset.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/laplace_stream_ctrl.sv
// Raster-stream 5-tap Laplace cross filter with line buffering and borders (LAPLACE_BORDER_REPLICATE_EN).
// Latency: output for center k is valid one cycle after input k+IMG_W+1 is accepted.
// Backpressure: in_ready = !out_valid || out_ready in RUN; output holds until accepted.
module laplace_stream_ctrl
    import laplace_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             out_last,
    output logic             busy
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_R = RW'(IMG_H - 1);

    state_t state_q, state_d;

    logic [CW-1:0] in_c_q, out_c_q;
    logic [RW-1:0] in_r_q, out_r_q;

    logic [PIX_W-1:0] w0_q, w1_q, b_q, h_q;
    logic [PIX_W-1:0] lba_out, lbb_out, push_pix;

    logic             out_valid_q, out_last_q;
    logic [PIX_W-1:0] out_pixel_q;

    logic in_fire, out_free, adv, emit, in_at_last, out_at_last;
    logic [PIX_W-1:0] result;

    assign out_free    = !out_valid_q || out_ready;
    assign in_fire     = in_valid && in_ready;
    assign in_at_last  = (in_r_q == LAST_R) && (in_c_q == LAST_C);
    assign out_at_last = (out_r_q == LAST_R) && (out_c_q == LAST_C);
    // In FLUSH the pipeline advances on a dummy pixel; only border centers remain.
    assign push_pix    = (state_q == FLUSH) ? '0 : in_pixel;

    // FSM next state, input-side ready and pipeline advance/emit strobes.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        adv      = 1'b0;
        emit     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = FILL;
            end
            FILL: begin
                in_ready = 1'b1;
                adv      = in_valid;
                if (in_valid && in_r_q == RW'(1) && in_c_q == '0) state_d = RUN;
            end
            RUN: begin
                in_ready = out_free;
                adv      = in_valid && out_free;
                emit     = in_valid && out_free;
                if (in_valid && out_free && in_at_last) state_d = FLUSH;
            end
            FLUSH: begin
                adv  = out_free;
                emit = out_free;
                if (out_free && out_at_last) state_d = DONE;
            end
            DONE: begin
                if (out_valid_q && out_ready && out_last_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Input and output raster counters, cleared on an accepted start.
    always_ff @(posedge clk) begin
        if (rst || (state_q == IDLE && start)) begin
            in_c_q  <= '0;
            in_r_q  <= '0;
            out_c_q <= '0;
            out_r_q <= '0;
        end else begin
            if (in_fire) begin
                if (in_c_q == LAST_C) begin
                    in_c_q <= '0;
                    in_r_q <= in_r_q + 1'b1;
                end else begin
                    in_c_q <= in_c_q + 1'b1;
                end
            end
            if (emit) begin
                if (out_c_q == LAST_C) begin
                    out_c_q <= '0;
                    out_r_q <= out_r_q + 1'b1;
                end else begin
                    out_c_q <= out_c_q + 1'b1;
                end
            end
        end
    end

    laplace_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_row_r (
        .clk    (clk),
        .en_i   (adv),
        .din_i  (push_pix),
        .dout_o (lba_out)
    );

    laplace_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_row_rm1 (
        .clk    (clk),
        .en_i   (adv),
        .din_i  (lba_out),
        .dout_o (lbb_out)
    );

    // Middle-row window (lba_out, w0, w1) plus one-pixel delays aligning b and h.
    always_ff @(posedge clk) begin
        if (adv) begin
            w0_q <= lba_out;
            w1_q <= w0_q;
            b_q  <= lbb_out;
            h_q  <= push_pix;
        end
    end

    // Kernel evaluation for the center selected by the output counter.
    always_comb begin
        logic [PIX_W-1:0] pb, pd, pe, pf, ph;
        logic signed [ACC_W-1:0] acc;
        logic border;
        pe = w0_q;
        pd = w1_q;
        pf = lba_out;
        pb = b_q;
        ph = h_q;
        border = (out_r_q == '0) || (out_r_q == LAST_R) ||
                 (out_c_q == '0) || (out_c_q == LAST_C);
`ifdef LAPLACE_BORDER_REPLICATE_EN
        // For a cross kernel, clamped coordinates always land on the center.
        if (out_r_q == '0)     pb = pe;
        if (out_r_q == LAST_R) ph = pe;
        if (out_c_q == '0)     pd = pe;
        if (out_c_q == LAST_C) pf = pe;
`endif
        acc = ACC_W'(pb) + ACC_W'(pd) + ACC_W'(pf) + ACC_W'(ph) - (ACC_W'(pe) << 2);
        result = clamp_pix(acc);
`ifndef LAPLACE_BORDER_REPLICATE_EN
        if (border) result = '0;
`else
        if (border) result = clamp_pix(acc);
`endif
    end

    // Output register: load on emit, drop valid once the sink accepts.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_last_q  <= 1'b0;
        end else if (emit) begin
            out_valid_q <= 1'b1;
            out_pixel_q <= result;
            out_last_q  <= out_at_last;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);

endmodule
